// File: rtl/gf2_mat_pkg.sv
// Shared types and helpers for the sequential GF(2) matrix multiplier.
package gf2_mat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Widest inner slice the dot helper accepts; narrower slices are zero-extended.
    localparam int DOT_MAX_W = 64;

    // GF(2) inner product: AND is multiply, XOR-reduce is the sum.
    function automatic logic gf2_dot(input logic [DOT_MAX_W-1:0] a_vec,
                                     input logic [DOT_MAX_W-1:0] b_vec);
        return ^(a_vec & b_vec);
    endfunction

endpackage

// File: rtl/gf2_dot_slice.sv
// Combinational partial product for one step: K_STEP inner terms for every (r,j).
module gf2_dot_slice
    import gf2_mat_pkg::*;
#(
    parameter int A_ROWS = 4,
    parameter int B_COLS = 1,
    parameter int K_STEP = 2
) (
    input  logic [A_ROWS*K_STEP-1:0] i_a_slice,  // (r,kk) at bit r*K_STEP+kk
    input  logic [K_STEP*B_COLS-1:0] i_b_slice,  // (kk,j) at bit kk*B_COLS+j
    output logic [A_ROWS*B_COLS-1:0] o_part      // (r,j)  at bit r*B_COLS+j
);

    if (K_STEP > DOT_MAX_W) begin : g_bad_width
        $error("gf2_dot_slice: K_STEP exceeds DOT_MAX_W");
    end

    for (genvar r = 0; r < A_ROWS; r++) begin : g_row
        for (genvar j = 0; j < B_COLS; j++) begin : g_col
            logic [K_STEP-1:0] w_bcol;
            for (genvar kk = 0; kk < K_STEP; kk++) begin : g_k
                assign w_bcol[kk] = i_b_slice[kk*B_COLS+j];
            end
            assign o_part[r*B_COLS+j] = gf2_dot(DOT_MAX_W'(i_a_slice[r*K_STEP +: K_STEP]),
                                                DOT_MAX_W'(w_bcol));
        end
    end

endmodule

// File: rtl/gf2_matmul_seq.sv
// Sequential GF(2) matrix multiplier C = A x B, K_STEP inner terms per cycle,
// with optional retention of A across operations.
module gf2_matmul_seq
    import gf2_mat_pkg::*;
#(
    parameter int A_ROWS = 4,
    parameter int A_COLS = 8,
    parameter int B_COLS = 1,
    parameter int K_STEP = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     a_keep,
    input  logic [A_ROWS*A_COLS-1:0] a_in,
    input  logic [A_COLS*B_COLS-1:0] b_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [A_ROWS*B_COLS-1:0] c_out,
    output logic                     busy
);

    localparam int STEPS  = A_COLS / K_STEP;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    if ((A_COLS % K_STEP) != 0) begin : g_bad_kstep
        $error("gf2_matmul_seq: K_STEP must divide A_COLS");
    end

    state_t                     r_state;
    state_t                     w_next;
    logic [STEP_W-1:0]          r_step;
    logic [A_ROWS*A_COLS-1:0]   r_a;
    logic [A_COLS*B_COLS-1:0]   r_b;
    logic [A_ROWS*B_COLS-1:0]   r_acc;
    logic [A_ROWS*B_COLS-1:0]   r_c;
    logic [A_ROWS*K_STEP-1:0]   w_a_slice;
    logic [K_STEP*B_COLS-1:0]   w_b_slice;
    logic [A_ROWS*B_COLS-1:0]   w_part;
    logic [A_ROWS*B_COLS-1:0]   w_acc_nxt;
    logic                       w_accept;
    logic                       w_last;

    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_state == ACCUM) && (r_step == LAST_STEP);
    assign w_acc_nxt = r_acc ^ w_part;
    assign c_out     = r_c;

    // Pick the K_STEP columns of A and rows of B consumed in the current step.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = r_b[int'(r_step)*K_STEP*B_COLS +: K_STEP*B_COLS];
        for (int r = 0; r < A_ROWS; r++) begin
            w_a_slice[r*K_STEP +: K_STEP] = r_a[r*A_COLS + int'(r_step)*K_STEP +: K_STEP];
        end
    end

    gf2_dot_slice #(
        .A_ROWS (A_ROWS),
        .B_COLS (B_COLS),
        .K_STEP (K_STEP)
    ) u_slice (
        .i_a_slice (w_a_slice),
        .i_b_slice (w_b_slice),
        .o_part    (w_part)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; DONE can hand straight back to ACCUM for back-to-back operands.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = ACCUM;
            ACCUM:   if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = in_valid ? ACCUM : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; out_ready -> in_ready is the only input-to-output path.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ACCUM: ;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: busy = 1'b0;
        endcase
    end

    // Operand capture, step-wise accumulation and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_c    <= '0;
        end else if (w_accept) begin
            r_step <= '0;
            r_b    <= b_in;
            r_acc  <= '0;
            if (!a_keep) r_a <= a_in;
        end else if (r_state == ACCUM) begin
            r_acc  <= w_acc_nxt;
            r_step <= w_last ? '0 : r_step + STEP_W'(1);
            if (w_last) r_c <= w_acc_nxt;
        end
    end

endmodule
